multicycle_sequencer: RTL and testbench
=======================================

Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM that sequences the MIPS datapath: a single shared memory, ALU, register file and PC, with IR/MDR/A/B/ALUOut holding registers.
- Replaces the single-cycle combinational decoder with a state machine.
- Supports variable-latency memory through a ready handshake.
- Sits between the instruction register opcode/funct fields, the ALU zero flag and every datapath enable and mux select.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles to wait for mem_ready in any memory state before entering ERROR; 0 disables the timeout.
- TMO_W, 5: width of the wait counter; must satisfy 2^TMO_W > MEM_TIMEOUT.

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current read or write this cycle
- sig_pc_write  out  1  load PC
- sig_ir_write  out  1  load IR (and MDR) from memory read data
- sig_iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- sig_mem_read  out  1  memory read request
- sig_mem_write  out  1  memory write request
- sig_reg_write  out  1  register file write enable
- sig_reg_dst  out  1  register write address select: 0 = rt, 1 = rd
- sig_mem_to_reg  out  1  register write data select: 0 = ALUOut, 1 = MDR
- sig_alu_src_a  out  1  ALU A input select: 0 = PC, 1 = A
- sig_alu_src_b  out  2  ALU B input select: 00 = B, 01 = 4, 10 = sext imm, 11 = sext imm<<2
- sig_pc_src  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- alu_op  out  3  ALU operation: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- error  out  1  sticky; set on illegal opcode/funct or memory timeout
- state  out  4  current state, for debug

Behaviour:
- States:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, ERROR=15.
- Outputs are Moore-decoded from state; sig_pc_write and sig_ir_write in FETCH additionally depend on mem_ready, and sig_pc_write in BRANCH on zero. Any output not listed for a state is 0 in that state; alu_op defaults to ADD.
- Reset:
  - reset high at a rising edge: state=FETCH, wait counter=0, error=0.
  - While reset is high, every strobe (pc_write, ir_write, mem_read, mem_write, reg_write) and instr_done is forced to 0; selects and alu_op show FETCH values (iord=0, src_a=0, src_b=01, pc_src=00, alu_op=010).
  - Reset mid-instruction abandons it; no partial write is issued.
- FETCH: mem_read=1, src_b=01, ADD. If mem_ready: ir_write=1, pc_write=1 (PC <- PC+4), go to DECODE; else stay.
- DECODE: src_a=0, src_b=11, ADD (branch target into ALUOut). Next state by opcode:
  - 000000 -> R_EXEC
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP (only with the feature enabled)
  - anything else -> ERROR
- MEM_ADDR: src_a=1, src_b=10, ADD. Go to MEM_RD for LW, MEM_WR for SW.
- MEM_RD: iord=1, mem_read=1. Wait for mem_ready, then go to MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1, go to FETCH.
- MEM_WR: iord=1, mem_write=1 held until mem_ready. On mem_ready: instr_done=1, go to FETCH.
- R_EXEC: src_a=1, src_b=00; alu_op from funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT. Any other funct -> ERROR with no write; otherwise go to R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_op held from funct, instr_done=1, go to FETCH.
- BRANCH: src_a=1, src_b=00, SUB, pc_src=01, pc_write=zero, instr_done=1, go to FETCH.
- ERROR: all strobes 0, error=1; stays in ERROR until reset.
- Wait counter:
  - Clears on every state change and increments each cycle spent in FETCH, MEM_RD or MEM_WR without mem_ready.
  - When the counter reaches MEM_TIMEOUT (and MEM_TIMEOUT != 0), go to ERROR at the next edge.
  - mem_ready in the same cycle as the timeout wins: the transfer completes normally.
- Latencies with mem_ready tied to 1: R-type 4 cycles, LW 5, SW 4, BEQ 3, J 3.

Optional Feature:
- Macro: MULTICYCLE_SEQUENCER_JUMP_EN.
- Defined: opcode 000010 in DECODE goes to JUMP. JUMP drives pc_src=10, pc_write=1, instr_done=1, then goes to FETCH.
- Undefined: JUMP state is absent and opcode 000010 goes to ERROR.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state encoding constants
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J
  - funct constants
  - ALU op constants
  - ALU_B and PC_SRC select encodings
- One sub-module, mips_alu_decoder: combinational funct -> alu_op plus an illegal flag, used in R_EXEC and R_WB.

Test Plan:
- mem_ready=1, reset, opcode=000000, funct=100000 -> states 0,1,6,7,0; reg_write and reg_dst=1 only in R_WB; alu_op=010; instr_done pulses once.
- LW (100011) with mem_ready low for 3 cycles in MEM_RD -> mem_read and iord held 4 cycles; reg_write with mem_to_reg=1 exactly one cycle later; total 8 cycles.
- BEQ with zero=1 -> pc_write=1 and pc_src=01 in BRANCH. Repeat with zero=0 -> pc_write=0, state returns to FETCH.
- opcode=111111 -> ERROR after DECODE, error=1, no strobe thereafter. Reset -> FETCH, error=0.
- MEM_TIMEOUT=16, mem_ready held 0 in FETCH -> ERROR entered 17 cycles after reset; mem_ready=1 exactly on the timeout cycle -> DECODE instead.
- Reset asserted during MEM_WR with mem_ready=0 -> mem_write=0 that cycle, state=FETCH next edge. With the macro defined, opcode=000010 -> JUMP with pc_src=10, pc_write=1.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control sequencer
// State, opcode, funct, ALU op and datapath select encodings used by the sequencer and its decoder.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXEC   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_ERROR    = 4'd15
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] ALU_B_REG    = 2'b00;
  localparam logic [1:0] ALU_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// rtl/mips_alu_decoder.sv - combinational R-type funct to ALU operation decoder
// Unknown funct codes raise illegal and fall back to ADD.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       illegal
);

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multi-cycle MIPS control FSM with ready-handshaked memory
// Optional J support is compiled in with MULTICYCLE_SEQUENCER_JUMP_EN.
module multicycle_sequencer
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TMO_W       = 5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       sig_pc_write,
  output logic       sig_ir_write,
  output logic       sig_iord,
  output logic       sig_mem_read,
  output logic       sig_mem_write,
  output logic       sig_reg_write,
  output logic       sig_reg_dst,
  output logic       sig_mem_to_reg,
  output logic       sig_alu_src_a,
  output logic [1:0] sig_alu_src_b,
  output logic [1:0] sig_pc_src,
  output logic [2:0] alu_op,
  output logic       instr_done,
  output logic       error,
  output logic [3:0] state
);

  state_e             state_q, state_d;
  logic [TMO_W-1:0]   wait_q, wait_d;
  logic               error_q, error_d;
  logic [2:0]         fn_alu_op;
  logic               fn_illegal;
  logic               mem_wait;
  logic               timed_out;

  mips_alu_decoder u_alu_dec (
    .funct   (funct),
    .alu_op  (fn_alu_op),
    .illegal (fn_illegal)
  );

  assign timed_out = (MEM_TIMEOUT != 0) && (wait_q == TMO_W'(MEM_TIMEOUT));
  assign mem_wait  = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) || (state_q == ST_MEM_WR);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    sig_pc_write   = 1'b0;
    sig_ir_write   = 1'b0;
    sig_iord       = 1'b0;
    sig_mem_read   = 1'b0;
    sig_mem_write  = 1'b0;
    sig_reg_write  = 1'b0;
    sig_reg_dst    = 1'b0;
    sig_mem_to_reg = 1'b0;
    sig_alu_src_a  = 1'b0;
    sig_alu_src_b  = ALU_B_REG;
    sig_pc_src     = PC_SRC_ALU;
    alu_op         = ALU_ADD;
    instr_done     = 1'b0;

    case (state_q)
      ST_FETCH: begin
        sig_mem_read  = 1'b1;
        sig_alu_src_b = ALU_B_FOUR;
        if (mem_ready) begin
          sig_ir_write = 1'b1;
          sig_pc_write = 1'b1;
          state_d      = ST_DECODE;
        end else if (timed_out) begin
          state_d = ST_ERROR;
        end
      end
      ST_DECODE: begin
        // Branch target is precomputed here so BRANCH can compare and select in one cycle.
        sig_alu_src_b = ALU_B_IMM_SH;
        case (opcode)
          OP_RTYPE:     state_d = ST_R_EXEC;
          OP_LW, OP_SW: state_d = ST_MEM_ADDR;
          OP_BEQ:       state_d = ST_BRANCH;
`ifdef MULTICYCLE_SEQUENCER_JUMP_EN
          OP_J:         state_d = ST_JUMP;
`endif
          default:      state_d = ST_ERROR;
        endcase
      end
      ST_MEM_ADDR: begin
        sig_alu_src_a = 1'b1;
        sig_alu_src_b = ALU_B_IMM;
        if (opcode == OP_LW)      state_d = ST_MEM_RD;
        else if (opcode == OP_SW) state_d = ST_MEM_WR;
        else                      state_d = ST_ERROR;
      end
      ST_MEM_RD: begin
        sig_iord     = 1'b1;
        sig_mem_read = 1'b1;
        if (mem_ready)      state_d = ST_MEM_WB;
        else if (timed_out) state_d = ST_ERROR;
      end
      ST_MEM_WB: begin
        sig_reg_write  = 1'b1;
        sig_mem_to_reg = 1'b1;
        instr_done     = 1'b1;
        state_d        = ST_FETCH;
      end
      ST_MEM_WR: begin
        sig_iord      = 1'b1;
        sig_mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = ST_FETCH;
        end else if (timed_out) begin
          state_d = ST_ERROR;
        end
      end
      ST_R_EXEC: begin
        sig_alu_src_a = 1'b1;
        alu_op        = fn_alu_op;
        state_d       = fn_illegal ? ST_ERROR : ST_R_WB;
      end
      ST_R_WB: begin
        sig_reg_write = 1'b1;
        sig_reg_dst   = 1'b1;
        alu_op        = fn_alu_op;
        instr_done    = 1'b1;
        state_d       = ST_FETCH;
      end
      ST_BRANCH: begin
        sig_alu_src_a = 1'b1;
        alu_op        = ALU_SUB;
        sig_pc_src    = PC_SRC_ALUOUT;
        sig_pc_write  = zero;
        instr_done    = 1'b1;
        state_d       = ST_FETCH;
      end
`ifdef MULTICYCLE_SEQUENCER_JUMP_EN
      ST_JUMP: begin
        sig_pc_src   = PC_SRC_JUMP;
        sig_pc_write = 1'b1;
        instr_done   = 1'b1;
        state_d      = ST_FETCH;
      end
`endif
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase

    // Reset abandons any instruction in flight: no strobe escapes, selects look like FETCH.
    if (reset) begin
      sig_pc_write   = 1'b0;
      sig_ir_write   = 1'b0;
      sig_mem_read   = 1'b0;
      sig_mem_write  = 1'b0;
      sig_reg_write  = 1'b0;
      instr_done     = 1'b0;
      sig_iord       = 1'b0;
      sig_reg_dst    = 1'b0;
      sig_mem_to_reg = 1'b0;
      sig_alu_src_a  = 1'b0;
      sig_alu_src_b  = ALU_B_FOUR;
      sig_pc_src     = PC_SRC_ALU;
      alu_op         = ALU_ADD;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)      wait_d = '0;
    else if (mem_wait && !mem_ready) wait_d = wait_q + 1'b1;
  end

  assign error_d = error_q | (state_d == ST_ERROR);
  assign error   = error_q;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb/tb_multicycle_sequencer.sv - randomized self-checking bench for multicycle_sequencer
// Expected per-cycle observations are built from instruction-level rules and memory delays.
module tb_multicycle_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       sig_pc_write, sig_ir_write, sig_iord, sig_mem_read, sig_mem_write;
  logic       sig_reg_write, sig_reg_dst, sig_mem_to_reg, sig_alu_src_a;
  logic [1:0] sig_alu_src_b, sig_pc_src;
  logic [2:0] alu_op;
  logic       instr_done, error;
  logic [3:0] state;

  multicycle_sequencer dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .sig_pc_write(sig_pc_write), .sig_ir_write(sig_ir_write),
    .sig_iord(sig_iord), .sig_mem_read(sig_mem_read), .sig_mem_write(sig_mem_write),
    .sig_reg_write(sig_reg_write), .sig_reg_dst(sig_reg_dst), .sig_mem_to_reg(sig_mem_to_reg),
    .sig_alu_src_a(sig_alu_src_a), .sig_alu_src_b(sig_alu_src_b), .sig_pc_src(sig_pc_src),
    .alu_op(alu_op), .instr_done(instr_done), .error(error), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, irw, mrd, mwr, rgw, done, iord, rdst, m2r, sa;
    logic [1:0] sb, ps;
    logic [2:0] alu;
    logic       err;
  } obs_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  obs_t exp_q[$];
  logic rdy_q[$];
  bit   err_pending;

  function automatic obs_t actual();
    obs_t o;
    o.st = state; o.pcw = sig_pc_write; o.irw = sig_ir_write; o.mrd = sig_mem_read;
    o.mwr = sig_mem_write; o.rgw = sig_reg_write; o.done = instr_done; o.iord = sig_iord;
    o.rdst = sig_reg_dst; o.m2r = sig_mem_to_reg; o.sa = sig_alu_src_a; o.sb = sig_alu_src_b;
    o.ps = sig_pc_src; o.alu = alu_op; o.err = error;
    return o;
  endfunction

  function automatic obs_t blank(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    o.alu = 3'b010;
    o.err = (st == 4'd15);
    return o;
  endfunction

  function automatic obs_t in_reset(input logic [3:0] st, input logic err);
    obs_t o;
    o = blank(st);
    o.sb = 2'b01;
    o.err = err;
    return o;
  endfunction

  function automatic bit ref_alu(input logic [5:0] fn, output logic [2:0] op);
    op = 3'b010;
    case (fn)
      6'b100000: op = 3'b010;
      6'b100010: op = 3'b110;
      6'b100100: op = 3'b000;
      6'b100101: op = 3'b001;
      6'b101010: op = 3'b111;
      default:   return 1'b0;
    endcase
    return 1'b1;
  endfunction

  task automatic push(input obs_t o, input logic rdy);
    exp_q.push_back(o);
    rdy_q.push_back(rdy);
  endtask

  task automatic push_error_tail();
    for (int i = 0; i < 3; i++) push(blank(4'd15), 1'($urandom_range(0, 1)));
    err_pending = 1'b1;
  endtask

  // Expected cycle-by-cycle view of one instruction: fd fetch stalls, md data stalls.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fd, input int md);
    obs_t o;
    logic [2:0] aop;
    bit legal;
    opcode = op; funct = fn; zero = z;
    o = blank(4'd0); o.mrd = 1'b1; o.sb = 2'b01;
    for (int i = 0; i < fd; i++) push(o, 1'b0);
    o.pcw = 1'b1; o.irw = 1'b1;
    push(o, 1'b1);
    o = blank(4'd1); o.sb = 2'b11;
    push(o, 1'($urandom_range(0, 1)));
    if (op == 6'b000000) begin
      legal = ref_alu(fn, aop);
      o = blank(4'd6); o.sa = 1'b1; o.alu = aop;
      push(o, 1'($urandom_range(0, 1)));
      if (!legal) push_error_tail();
      else begin
        o = blank(4'd7); o.rgw = 1'b1; o.rdst = 1'b1; o.done = 1'b1; o.alu = aop;
        push(o, 1'($urandom_range(0, 1)));
      end
    end else if (op == 6'b100011 || op == 6'b101011) begin
      o = blank(4'd2); o.sa = 1'b1; o.sb = 2'b10;
      push(o, 1'($urandom_range(0, 1)));
      if (op == 6'b100011) begin
        o = blank(4'd3); o.iord = 1'b1; o.mrd = 1'b1;
        for (int i = 0; i < md; i++) push(o, 1'b0);
        push(o, 1'b1);
        o = blank(4'd4); o.rgw = 1'b1; o.m2r = 1'b1; o.done = 1'b1;
        push(o, 1'($urandom_range(0, 1)));
      end else begin
        o = blank(4'd5); o.iord = 1'b1; o.mwr = 1'b1;
        for (int i = 0; i < md; i++) push(o, 1'b0);
        o.done = 1'b1;
        push(o, 1'b1);
      end
    end else if (op == 6'b000100) begin
      o = blank(4'd8); o.sa = 1'b1; o.alu = 3'b110; o.ps = 2'b01; o.pcw = z; o.done = 1'b1;
      push(o, 1'($urandom_range(0, 1)));
`ifdef MULTICYCLE_SEQUENCER_JUMP_EN
    end else if (op == 6'b000010) begin
      o = blank(4'd9); o.ps = 2'b10; o.pcw = 1'b1; o.done = 1'b1;
      push(o, 1'($urandom_range(0, 1)));
`endif
    end else begin
      push_error_tail();
    end
  endtask

  task automatic run_queue(input string tag);
    obs_t e, a;
    logic r;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      r = rdy_q.pop_front();
      @(negedge clock);
      mem_ready = r;
      #1;
      a = actual();
      n_cmp++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s op=%b fn=%b z=%b: got %h want %h", tag, opcode, funct, zero, a, e);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    err_pending = 1'b0;
  endtask

  task automatic test_reset();
    obs_t a;
    reset = 1'b1;
    mem_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    a = actual();
    n_cmp++;
    if (a !== in_reset(4'd0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want %h", a, in_reset(4'd0, 1'b0));
    end
    do_reset();
  endtask

  task automatic test_directed();
    build(6'b000000, 6'b100000, 1'b0, 0, 0); run_queue("rtype_add");
    build(6'b100011, 6'b000000, 1'b0, 0, 3); run_queue("lw_wait3");
    build(6'b101011, 6'b000000, 1'b0, 0, 0); run_queue("sw");
    build(6'b000100, 6'b000000, 1'b1, 0, 0); run_queue("beq_taken");
    build(6'b000100, 6'b000000, 1'b0, 0, 0); run_queue("beq_not_taken");
    build(6'b000010, 6'b000000, 1'b0, 0, 0); run_queue("jump");
    if (err_pending) do_reset();
  endtask

  task automatic test_illegal();
    obs_t a;
    build(6'b111111, 6'b000000, 1'b0, 1, 0);
    run_queue("illegal_op");
    @(negedge clock);
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    a = actual();
    n_cmp++;
    if (a !== in_reset(4'd15, 1'b1)) begin
      n_fail++;
      $display("FAIL reset_in_error: got %h want %h", a, in_reset(4'd15, 1'b1));
    end
    @(posedge clock);
    #1;
    a = actual();
    n_cmp++;
    if (a !== in_reset(4'd0, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_from_error: got %h want %h", a, in_reset(4'd0, 1'b0));
    end
    reset = 1'b0;
    err_pending = 1'b0;
    build(6'b000000, 6'b000001, 1'b0, 0, 0);
    run_queue("illegal_funct");
    do_reset();
  endtask

  task automatic test_timeout();
    int cyc;
    cyc = -1;
    mem_ready = 1'b0;
    do_reset();
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (state == 4'd15) begin
        cyc = i;
        break;
      end
    end
    n_cmp++;
    if (cyc != 17 || error !== 1'b1) begin
      n_fail++;
      $display("FAIL fetch_timeout: got cycles=%0d error=%b want cycles=17 error=1", cyc, error);
    end
    do_reset();
    build(6'b100011, 6'b000000, 1'b0, 16, 16);
    run_queue("ready_on_timeout");
  endtask

  task automatic test_reset_mid_write();
    obs_t a;
    do_reset();
    opcode = 6'b101011;
    mem_ready = 1'b1;
    repeat (2) begin @(posedge clock); #1; end
    mem_ready = 1'b0;
    @(posedge clock);
    #1;
    n_cmp++;
    if (state !== 4'd5 || sig_mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_mem_wr: got state=%0d mem_write=%b want state=5 mem_write=1", state, sig_mem_write);
    end
    reset = 1'b1;
    #1;
    a = actual();
    n_cmp++;
    if (a !== in_reset(4'd5, 1'b0)) begin
      n_fail++;
      $display("FAIL reset_mid_write: got %h want %h", a, in_reset(4'd5, 1'b0));
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_mid_state: got %0d want 0", state);
    end
    reset = 1'b0;
    err_pending = 1'b0;
  endtask

  task automatic test_random();
    logic [5:0] fns[5];
    logic [5:0] op, fn;
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    for (int n = 0; n < 60; n++) begin
      fn = fns[$urandom_range(0, 4)];
      case ($urandom_range(0, 9))
        0, 1, 2: begin
          op = 6'b000000;
          if ($urandom_range(0, 4) == 0) fn = 6'($urandom);
        end
        3, 4:    op = 6'b100011;
        5:       op = 6'b101011;
        6, 7:    op = 6'b000100;
        8:       op = 6'b000010;
        default: op = 6'($urandom);
      endcase
      build(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 4));
      run_queue("random");
      if (err_pending) do_reset();
    end
  endtask

  initial begin
    err_pending = 1'b0;
    test_reset();
    test_directed();
    test_illegal();
    test_timeout();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
